// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a program image over an 8N1 UART line, writes it
// word by word into instruction memory, verifies an additive checksum and then
// releases the core from reset.
//
// Frame: 0xA5, count lo, count hi, count*4 data bytes (little-endian words),
// then one checksum byte (mod-256 sum of the data bytes).
module uart_boot_loader #(
    parameter int          CLOCK_FREQ = 25000000,
    parameter int          BIT_RATE   = 115200,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          MAX_WORDS  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset_o,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BIT_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [16:0]      MAX_N     = 17'(MAX_WORDS);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;

    // Receiver states
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Loader states
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_COUNT_LO = 3'd1;
    localparam logic [2:0] S_COUNT_HI = 3'd2;
    localparam logic [2:0] S_DATA     = 3'd3;
    localparam logic [2:0] S_CHECK    = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    // Receiver state
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [1:0]       rx_state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       rx_shift;
    logic             byte_valid;
    logic [7:0]       rx_byte;
    logic             frame_err;

    // Loader state
    logic [2:0]  state;
    logic [15:0] word_cnt;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] word_sh;
    logic [7:0]  csum;

    logic [15:0] count_full;
    assign count_full = {rx_byte, word_cnt[7:0]};

    // Two-flop synchronizer plus a delayed copy for start-edge detection.
    // Reset to the idle-high level so reset release never looks like a start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // 8N1 receiver: half-bit start qualification, then centre sampling.
    // It drops back to idle at the stop-bit centre so a start bit that
    // immediately follows the stop bit is still caught by its falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state   <= RX_IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    if (rx_prev && !rx_sync)
                        rx_state <= RX_START;
                end
                RX_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt  <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt  <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (bit_cnt == 3'd7)
                            rx_state <= RX_STOP;
                        else
                            bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= rx_shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Frame parser: count, word assembly, memory write and checksum verdict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            word_cnt    <= '0;
            word_idx    <= '0;
            byte_cnt    <= '0;
            word_sh     <= '0;
            csum        <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_reset_o <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (frame_err) begin
                // A bad stop bit abandons any frame in progress; a finished
                // load is never disturbed.
                if (state != S_DONE) begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            end else if (byte_valid) begin
                case (state)
                    S_IDLE: begin
                        if (rx_byte == SYNC_BYTE) begin
                            state <= S_COUNT_LO;
                            busy  <= 1'b1;
                            error <= 1'b0;
                            csum  <= '0;
                        end
                    end
                    S_COUNT_LO: begin
                        word_cnt[7:0] <= rx_byte;
                        state         <= S_COUNT_HI;
                    end
                    S_COUNT_HI: begin
                        word_cnt <= count_full;
                        word_idx <= '0;
                        byte_cnt <= '0;
                        csum     <= '0;
                        if ({1'b0, count_full} > MAX_N) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else if (count_full == 16'd0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        word_sh  <= {rx_byte, word_sh[23:8]};
                        csum     <= csum + rx_byte;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                            mem_wdata <= {rx_byte, word_sh};
                            word_idx  <= word_idx + 1'b1;
                            if (word_idx == word_cnt - 16'd1)
                                state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        busy <= 1'b0;
                        if (rx_byte == csum) begin
                            done        <= 1'b1;
                            cpu_reset_o <= 1'b0;
                            state       <= S_DONE;
                        end else begin
                            error <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                    S_DONE: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Testbench for uart_boot_loader: drives UART frames on rx and checks memory
// writes against a scoreboard of expected (address, data) pairs.
module tb_uart_boot_loader;

    localparam int CF  = 1_600_000;
    localparam int BR  = 100_000;
    localparam int CPB = CF / BR;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx = 1'b1;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset_o;
    logic        busy;
    logic        done;
    logic        error;

    int  errors = 0;
    int  checks = 0;
    wr_t exp_q[$];
    wr_t mon_e;
    logic prev_we = 1'b0;

    uart_boot_loader #(
        .CLOCK_FREQ(CF),
        .BIT_RATE  (BR),
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (1024)
    ) dut (
        .clk        (clk),
        .reset      (reset_n),
        .rx         (rx),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset_o(cpu_reset_o),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Write monitor: every strobe pops the scoreboard and must be one cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data) begin
                    errors++;
                    $display("FAIL write_value: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_wdata, mon_e.addr, mon_e.data);
                end
            end
            checks++;
            if (prev_we) begin
                errors++;
                $display("FAIL we_pulse: got mem_we high 2 cycles, required 1");
            end
        end
        prev_we = mem_we;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        // A low stop bit needs idle high time before the next start edge.
        if (!stop_bit) repeat (CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    function automatic logic [7:0] sum_bytes(input logic [31:0] a, input logic [31:0] b);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 4; i++) s = s + a[8*i +: 8] + b[8*i +: 8];
        return s;
    endfunction

    // Sends the two-word image; words are expected in memory whatever the checksum.
    task automatic load_two(input logic [7:0] cks, input logic skip_sync);
        wr_t e;
        if (!skip_sync) send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        e.addr = 32'h0; e.data = 32'h1234_5678; exp_q.push_back(e);
        e.addr = 32'h4; e.data = 32'hDEAD_BEEF; exp_q.push_back(e);
        send_word(32'h1234_5678);
        send_word(32'hDEAD_BEEF);
        send_byte(cks, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (mem_we !== 1'b0)        begin errors++; $display("FAIL rst_we: got %b, required 0", mem_we); end
        checks++; if (mem_addr !== 32'h0)     begin errors++; $display("FAIL rst_addr: got %h, required 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0)    begin errors++; $display("FAIL rst_wdata: got %h, required 0", mem_wdata); end
        checks++; if (cpu_reset_o !== 1'b1)   begin errors++; $display("FAIL rst_cpu_reset: got %b, required 1", cpu_reset_o); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
        checks++; if (done !== 1'b0)          begin errors++; $display("FAIL rst_done: got %b, required 0", done); end
        checks++; if (error !== 1'b0)         begin errors++; $display("FAIL rst_error: got %b, required 0", error); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_glitch();
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL glitch_busy: got %b, required 0", busy); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL glitch_error: got %b, required 0", error); end
        // Receiver must still be able to take a real sync byte afterwards.
        send_byte(8'hA5, 1'b1);
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL glitch_sync_busy: got %b, required 1", busy); end
        do_reset();
    endtask

    task automatic test_good_load();
        logic [7:0] cks;
        cks = sum_bytes(32'h1234_5678, 32'hDEAD_BEEF);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_noise_busy: got %b, required 0", busy); end
        send_byte(8'hA5, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_sync_busy: got %b, required 1", busy); end
        load_two(cks, 1'b1);
        checks++; if (done !== 1'b1)        begin errors++; $display("FAIL good_done: got %b, required 1", done); end
        checks++; if (cpu_reset_o !== 1'b0) begin errors++; $display("FAIL good_cpu_reset: got %b, required 0", cpu_reset_o); end
        checks++; if (error !== 1'b0)       begin errors++; $display("FAIL good_error: got %b, required 0", error); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL good_busy: got %b, required 0", busy); end
        checks++; if (exp_q.size() !== 0)   begin errors++; $display("FAIL good_writes: got %0d pending, required 0", exp_q.size()); end
        // DONE absorbs any later traffic.
        send_byte(8'hA5, 1'b1);
        checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL done_absorb: got busy=%b done=%b, required busy=0 done=1", busy, done); end
        do_reset();
    endtask

    task automatic test_bad_checksum();
        logic [7:0] cks;
        cks = sum_bytes(32'h1234_5678, 32'hDEAD_BEEF);
        load_two(cks + 8'h01, 1'b0);
        checks++; if (error !== 1'b1)       begin errors++; $display("FAIL badck_error: got %b, required 1", error); end
        checks++; if (cpu_reset_o !== 1'b1) begin errors++; $display("FAIL badck_cpu_reset: got %b, required 1", cpu_reset_o); end
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL badck_done: got %b, required 0", done); end
        send_byte(8'hA5, 1'b1);
        checks++; if (error !== 1'b0)       begin errors++; $display("FAIL retry_error_clear: got %b, required 0", error); end
        load_two(cks, 1'b1);
        checks++; if (done !== 1'b1)        begin errors++; $display("FAIL retry_done: got %b, required 1", done); end
        checks++; if (cpu_reset_o !== 1'b0) begin errors++; $display("FAIL retry_cpu_reset: got %b, required 0", cpu_reset_o); end
        checks++; if (exp_q.size() !== 0)   begin errors++; $display("FAIL retry_writes: got %0d pending, required 0", exp_q.size()); end
        do_reset();
    endtask

    task automatic test_count_overflow();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h04, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_error: got %b, required 1", error); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL ovf_busy: got %b, required 0", busy); end
        // Back in IDLE: a fresh empty frame completes.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (done !== 1'b1)  begin errors++; $display("FAIL ovf_recover_done: got %b, required 1", done); end
        do_reset();
    endtask

    task automatic test_framing();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b0);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL frame_error: got %b, required 1", error); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL frame_busy: got %b, required 0", busy); end
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL frame_recover: got done=%b error=%b, required done=1 error=0", done, error); end
        checks++; if (cpu_reset_o !== 1'b0) begin errors++; $display("FAIL frame_cpu_reset: got %b, required 0", cpu_reset_o); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        wr_t e;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        e.addr = 32'h0; e.data = 32'h1234_5678; exp_q.push_back(e);
        send_word(32'h1234_5678);
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (mem_wdata !== 32'h0)  begin errors++; $display("FAIL mid_wdata: got %h, required 0", mem_wdata); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL mid_busy: got %b, required 0", busy); end
        checks++; if (cpu_reset_o !== 1'b1) begin errors++; $display("FAIL mid_cpu_reset: got %b, required 1", cpu_reset_o); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        load_two(sum_bytes(32'h1234_5678, 32'hDEAD_BEEF), 1'b0);
        checks++; if (done !== 1'b1)      begin errors++; $display("FAIL mid_resend_done: got %b, required 1", done); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL mid_writes: got %0d pending, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_good_load();
        test_bad_checksum();
        test_count_overflow();
        test_framing();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Sits between the board UART pin and the `Grande_Risco_5_SOC` memory write port, and loads a program image sent by a host over UART. It holds the core in reset while loading, writes each received 32-bit word into instruction memory, checks a checksum, then releases the core. A built-in 8N1 receiver handles the line. It is the host-to-device end of the same UART link on which the SoC transmits.

## Interface
- `CLOCK_FREQ`, 25000000: system clock frequency in Hz.
- `BIT_RATE`, 115200: UART baud rate. `CLKS_PER_BIT` = `CLOCK_FREQ / BIT_RATE`, using truncating integer division (217 at the defaults).
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `MAX_WORDS`, 1024: largest accepted word count (4096-byte memory).
- `clk`  input  1  system clock; all state is on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = reset).
- `rx`  input  1  UART serial input; idles high; asynchronous to `clk`.
- `mem_we`  output  1  one-cycle word write strobe.
- `mem_addr`  output  32  byte address of the write; always word-aligned.
- `mem_wdata`  output  32  write data.
- `cpu_reset_o`  output  1  active-high core reset; held at 1 until a load succeeds.
- `busy`  output  1  high from an accepted sync byte until DONE or an error.
- `done`  output  1  load completed with a good checksum; sticky until `reset`.
- `error`  output  1  sticky error flag; cleared when the next sync byte is accepted.

## Operation
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_reset_o`=1, `busy`=0, `done`=0, `error`=0. The FSM starts in IDLE.
- Receiver:
  - `rx` passes through a 2-flop synchronizer.
  - A falling edge in idle starts a half-bit count. At half-bit the line is resampled; if it is high, the start is discarded as a glitch.
  - The 8 data bits are sampled at bit centres, every `CLKS_PER_BIT` cycles, LSB first.
  - The stop bit is sampled at its centre. If it is 1, a one-cycle `byte_valid` pulse is issued with the byte. If it is 0, a framing error is raised and no byte is delivered.
- Frame format: 0xA5 sync, then count low byte, then count high byte (N, 16-bit), then N×4 data bytes with each word little-endian, then one checksum byte. The checksum is the 8-bit mod-256 sum of all data bytes.
- FSM states: IDLE → COUNT_LO → COUNT_HI → DATA → CHECK → DONE.
  - IDLE: 0xA5 moves to COUNT_LO, sets `busy`, clears `error`. Any other byte is ignored.
  - COUNT_HI: if N > `MAX_WORDS`, set `error` and go to IDLE. If N = 0, go straight to CHECK. Otherwise go to DATA with the word index at 0.
  - DATA: bytes are shifted into the word register, low byte first, and added to the checksum.
    - On the 4th byte: `mem_addr` = `BASE_ADDR` + 4×index, `mem_wdata` = the assembled word, and `mem_we` pulses.
    - After word N-1 the FSM goes to CHECK.
  - CHECK: a matching checksum sets `done`, clears `cpu_reset_o` to 0, and goes to DONE. A mismatch sets `error`, keeps `cpu_reset_o`=1, and goes to IDLE.
  - DONE: absorbing state; all received bytes are ignored until `reset`.
- A framing error in any state other than DONE sets `error` and returns the FSM to IDLE, discarding the partial word and checksum. In IDLE the error flag is set but the state is unchanged.
- Words already written before an error stay in memory. A retry overwrites them.
- `cpu_reset_o` never returns to 1 except through `reset`.

## Timing
- `mem_we` rises in the cycle after the `byte_valid` of a word's 4th byte and lasts exactly 1 cycle. `mem_addr` and `mem_wdata` are valid in that cycle and hold their values until the next write.
- `done` rises and `cpu_reset_o` falls in the cycle after the checksum byte's `byte_valid`. `busy` falls in the same cycle.
- `byte_valid` occurs about 9.5 bit times after the start edge, plus 2 synchronizer cycles.
- Back-to-back bytes with no idle time between them are handled, because the receiver re-arms from the stop-bit centre.
- Asserting `reset` during a load forces all outputs to their reset values immediately. Any partial frame is lost.

## Test plan
- Load N=2, words 0x12345678 and 0xDEADBEEF, checksum 0x4C → writes (0x0, 0x12345678) then (0x4, 0xDEADBEEF), each a 1-cycle `mem_we`. `cpu_reset_o` then falls to 0, `done`=1, `error`=0.
- Same frame with checksum 0x4D → `error`=1 and `cpu_reset_o` stays 1. Resending the frame with 0x4C → `error` clears at the sync byte, and the load then completes with `done`=1.
- Count of 1025 (bytes 0x01, 0x04) → `error`=1, no `mem_we`, FSM back in IDLE. Bytes 0x00 0x00 before 0xA5 are ignored.
- Stop bit forced to 0 on the 3rd data byte → no write of word 0, `error`=1. Next 0xA5 frame with N=0 and checksum 0x00 → `done`=1.
- `rx` low pulse shorter than `CLKS_PER_BIT`/2 cycles → no `byte_valid`, no state change.
- `reset` low midway through word 1 of an N=2 load → all outputs return to reset values. A full resend then succeeds.
